// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_pkg
// Description : Shared types and constants for the PISO serializer slice.
//               state_t   - serializer FSM states (IDLE, SHIFT)
//               SER_WIDTH_DEFAULT - default parallel word width
// Revision    : 1.0 - initial release
// ============================================================================
package piso_serializer_pkg;

    localparam int SER_WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : piso_serializer_pkg
`default_nettype wire

// File: rtl/piso_serializer_bit_select_mux.sv
`default_nettype none
// ============================================================================
// Module      : bit_select_mux
// Description : Combinational WIDTH:1 part-select bit mux. The 8-bit build is
//               pin-compatible with the existing 8:1 bit mux.
// Ports       : data    [WIDTH-1:0] in  - word to select from
//               sel     [SEL_W-1:0] in  - bit index
//               bit_out             out - data[sel]
// Revision    : 1.0 - initial release
// ============================================================================
module bit_select_mux
    import piso_serializer_pkg::*;
#(
    parameter int  WIDTH = SER_WIDTH_DEFAULT,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SEL_W-1:0] sel,
    output logic             bit_out
);

    assign bit_out = data[sel];

endmodule : bit_select_mux
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in / serial-out stage. Accepts a WIDTH-bit word over
//               a valid/ready handshake and emits it one bit per clock with
//               valid, start and done strobes. Back-to-back frames are
//               accepted on the last bit of the current frame (no bubble).
// Ports       : clk, rst (async, active-high)
//               in_data/in_valid/in_ready - parallel word handshake
//               ser_out/ser_valid         - serial bit stream
//               sel                       - current bit index (debug)
//               frame_start/frame_done    - first/last bit strobes
//               busy                      - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int  WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit  LSB_FIRST = 1'b1,
    localparam int SEL_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [SEL_W-1:0] sel,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic [SEL_W-1:0] cnt, cnt_n;
    logic             accept;
    logic             last_bit;
    logic             mux_bit;

    // Decode strictly from registers so the strobes are glitch-free and
    // in_ready never depends combinationally on in_valid.
    assign last_bit    = (cnt == LAST);
    assign in_ready    = (state == IDLE) || ((state == SHIFT) && last_bit);
    assign accept      = in_valid && in_ready;
    assign sel         = LSB_FIRST ? cnt : SEL_W'(LAST - cnt);
    assign busy        = (state == SHIFT);
    assign ser_valid   = busy;
    assign frame_start = busy && (cnt == '0);
    assign frame_done  = busy && last_bit;
    assign ser_out     = busy && mux_bit;

    bit_select_mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .data    (data_q),
        .sel     (sel),
        .bit_out (mux_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            data_q <= data_n;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        data_n  = data_q;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    data_n  = in_data;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    cnt_n = cnt + 1'b1;
                end else if (accept) begin
                    // Chain straight into the next frame.
                    data_n = in_data;
                    cnt_n  = '0;
                end else begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Directed self-checking bench for piso_serializer. Three
//               builds: WIDTH=8 LSB-first (a_*), WIDTH=8 MSB-first (b_*),
//               WIDTH=5 LSB-first (c_*).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_data, b_data;
    logic [4:0] c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, b_ready, c_ready;
    logic       a_ser, b_ser, c_ser;
    logic       a_sv, b_sv, c_sv;
    logic [2:0] a_sel, b_sel, c_sel;
    logic       a_fs, b_fs, c_fs;
    logic       a_fd, b_fd, c_fd;
    logic       a_busy, b_busy, c_busy;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .ser_out(a_ser), .ser_valid(a_sv), .sel(a_sel),
        .frame_start(a_fs), .frame_done(a_fd), .busy(a_busy));

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .ser_out(b_ser), .ser_valid(b_sv), .sel(b_sel),
        .frame_start(b_fs), .frame_done(b_fd), .busy(b_busy));

    piso_serializer #(.WIDTH(5), .LSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid),
        .in_ready(c_ready), .ser_out(c_ser), .ser_valid(c_sv), .sel(c_sel),
        .frame_start(c_fs), .frame_done(c_fd), .busy(c_busy));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pat;
    logic [7:0] pat2;
    logic [4:0] pat5;

    initial begin
        a_data = '0; b_data = '0; c_data = '0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("rst_ready",  a_ready, 1);
        check("rst_sv",     a_sv,    0);
        check("rst_busy",   a_busy,  0);
        check("rst_ser",    a_ser,   0);
        check("rst_fs",     a_fs,    0);
        check("rst_fd",     a_fd,    0);
        check("rst_sel_l",  a_sel,   0);
        check("rst_sel_m",  b_sel,   7);
        check("rst_sel_5",  c_sel,   0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ---------------- 8'b11001101, both bit orders ----------------
        pat    = 8'b11001101;
        a_data = pat; b_data = pat;
        a_valid = 1'b1; b_valid = 1'b1;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("lsb_ser",  a_ser, pat[i]);
            check("lsb_sv",   a_sv,  1);
            check("lsb_sel",  a_sel, i);
            check("lsb_fs",   a_fs,  i == 0);
            check("lsb_fd",   a_fd,  i == 7);
            check("msb_ser",  b_ser, pat[7-i]);
            check("msb_sel",  b_sel, 7 - i);
            check("msb_fd",   b_fd,  i == 7);
            tick();
        end
        check("lsb_end_sv", a_sv, 0);
        check("msb_end_sv", b_sv, 0);
        check("lsb_end_rdy", a_ready, 1);

        // ---------------- back-to-back A5 then 3C ----------------
        pat     = 8'hA5;
        pat2    = 8'h3C;
        a_data  = pat;
        a_valid = 1'b1;
        tick();
        a_data = pat2;
        for (int i = 0; i < 16; i++) begin
            check("b2b_ser", a_ser, (i < 8) ? pat[i % 8] : pat2[i % 8]);
            check("b2b_sv",  a_sv,  1);
            check("b2b_fd",  a_fd,  (i == 7) || (i == 15));
            check("b2b_fs",  a_fs,  (i == 0) || (i == 8));
            if (i == 7) check("b2b_rdy7", a_ready, 1);
            tick();
            if (i == 7) a_valid = 1'b0;
        end
        check("b2b_end_sv", a_sv, 0);

        // ---------------- ignored in_valid mid-frame ----------------
        a_data  = 8'h00;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                a_data  = 8'hFF;
                a_valid = 1'b1;
            end
            check("hold_ser", a_ser,   0);
            check("hold_rdy", a_ready, i == 7);
            tick();
        end
        a_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("ff_ser", a_ser, 1);
            check("ff_sv",  a_sv,  1);
            tick();
        end
        check("ff_end_sv", a_sv, 0);

        // ---------------- async reset mid-frame at cnt=4 ----------------
        a_data  = 8'hFF;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        repeat (4) tick();
        check("pre_rst_sel", a_sel, 4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sv",   a_sv,    0);
        check("arst_busy", a_busy,  0);
        check("arst_rdy",  a_ready, 1);
        check("arst_ser",  a_ser,   0);
        check("arst_sel",  a_sel,   0);
        #1;
        rst = 1'b0;
        pat     = 8'h01;
        a_data  = pat;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("post_ser", a_ser, pat[i]);
            check("post_sel", a_sel, i);
            check("post_fs",  a_fs,  i == 0);
            tick();
        end
        check("post_end_sv", a_sv, 0);

        // ---------------- WIDTH=5, two chained frames ----------------
        pat5    = 5'b10110;
        c_data  = pat5;
        c_valid = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("w5_ser", c_ser, pat5[i % 5]);
            check("w5_sel", c_sel, i % 5);
            check("w5_fd",  c_fd,  (i % 5) == 4);
            check("w5_fs",  c_fs,  (i % 5) == 0);
            check("w5_sv",  c_sv,  1);
            tick();
            if (i == 4) c_valid = 1'b0;
        end
        check("w5_end_sv",  c_sv,  0);
        check("w5_end_sel", c_sel, 0);
        check("w5_end_fd",  c_fd,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_piso_serializer
`default_nettype wire
